// File: rtl/smbus_bidir_relay.sv
// N-channel open-drain relay for SMBus/I2C lines between a host segment (A) and
// a device segment (B). Each channel synchronises and filters both pads, then a
// small FSM decides which side owns the line and mirrors its low onto the other.
module smbus_bidir_relay #(
  parameter int unsigned NUM_CH      = 6,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned HOLDOFF_CYC = 8,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [NUM_CH-1:0] iEnable,
  input  logic [NUM_CH-1:0] iA,
  input  logic [NUM_CH-1:0] iB,
  output logic [NUM_CH-1:0] oA_oe,
  output logic [NUM_CH-1:0] oB_oe,
  output logic [NUM_CH-1:0] oStuck,
  output logic [NUM_CH-1:0] oBusy
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    StIdle,
    StADrives,
    StBDrives,
    StRelease,
    StStuck
  } state_e;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Index 0 is the A side, index 1 the B side.
    logic [1:0]            pad;
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            filt_q, filt_d;
    logic [FILTER_LEN-1:0] hist_q [2];
    logic [FILTER_LEN-1:0] hist_d [2];
    state_e                state_q, state_d;
    logic [TimerW-1:0]     timer_q, timer_d;

    assign pad = {iB[i], iA[i]};

    // Input conditioning: two-flop synchroniser, history shift, unanimous filter.
    always_comb begin
      sync1_d = pad;
      sync2_d = sync1_q;
      for (int s = 0; s < 2; s++) begin
        hist_d[s] = FILTER_LEN'({hist_q[s], sync2_q[s]});
        filt_d[s] = filt_q[s];
        if (&hist_q[s]) begin
          filt_d[s] = 1'b1;
        end else if (~|hist_q[s]) begin
          filt_d[s] = 1'b0;
        end
      end
    end

    // Direction arbitration and channel timer.
    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      unique case (state_q)
        StIdle: begin
          // A wins a simultaneous fall.
          if (!filt_q[0]) begin
            state_d = StADrives;
          end else if (!filt_q[1]) begin
            state_d = StBDrives;
          end
        end
        StADrives: begin
          // The B level is our own echo here, so only A is watched.
          if (filt_q[0]) begin
            state_d = StRelease;
          end else if (timer_q == TimerW'(TIMEOUT_CYC - 1)) begin
            // Timer would reach TIMEOUT_CYC on this edge.
            state_d = StStuck;
          end
        end
        StBDrives: begin
          if (filt_q[1]) begin
            state_d = StRelease;
          end else if (timer_q == TimerW'(TIMEOUT_CYC - 1)) begin
            state_d = StStuck;
          end
        end
        StRelease: begin
          // Ignore both inputs while the released side's echo decays.
          if (timer_q == TimerW'(HOLDOFF_CYC - 1)) begin
            state_d = StIdle;
          end
        end
        StStuck: begin
          if (&filt_q) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase

      if ((state_q == StADrives || state_q == StBDrives || state_q == StRelease) &&
          timer_q != TimerW'(TIMEOUT_CYC)) begin
        timer_d = timer_q + 1'b1;
      end

      if (!iEnable[i]) begin
        state_d = StIdle;
      end

      if (state_d != state_q) begin
        timer_d = '0;
      end
    end

    // State, timer and conditioning registers; reset leaves both lines released.
    always_ff @(posedge iClk) begin
      if (iRst) begin
        sync1_q   <= '1;
        sync2_q   <= '1;
        filt_q    <= '1;
        hist_q[0] <= '1;
        hist_q[1] <= '1;
        state_q   <= StIdle;
        timer_q   <= '0;
      end else begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
        filt_q  <= filt_d;
        hist_q  <= hist_d;
        state_q <= state_d;
        timer_q <= timer_d;
      end
    end

    assign oB_oe[i]  = (state_q == StADrives);
    assign oA_oe[i]  = (state_q == StBDrives);
    assign oStuck[i] = (state_q == StStuck);
    assign oBusy[i]  = (state_q != StIdle);
  end

endmodule

// File: tb/tb_smbus_bidir_relay.sv
// Directed bench for smbus_bidir_relay with two channels, 4-deep filter,
// 8-cycle hold-off and 100-cycle timeout.
module tb_smbus_bidir_relay;

  localparam int unsigned NCh = 2;

  logic           clk;
  logic           rst;
  logic [NCh-1:0] en;
  logic [NCh-1:0] a;
  logic [NCh-1:0] b;
  logic [NCh-1:0] a_oe;
  logic [NCh-1:0] b_oe;
  logic [NCh-1:0] stuck;
  logic [NCh-1:0] busy;

  int  n_assert = 0;
  int  n_fail   = 0;
  bit  echo_b0  = 1'b0;

  smbus_bidir_relay #(
    .NUM_CH     (NCh),
    .FILTER_LEN (4),
    .HOLDOFF_CYC(8),
    .TIMEOUT_CYC(100)
  ) dut (
    .iClk   (clk),
    .iRst   (rst),
    .iEnable(en),
    .iA     (a),
    .iB     (b),
    .oA_oe  (a_oe),
    .oB_oe  (b_oe),
    .oStuck (stuck),
    .oBusy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; outputs are sampled 1 time unit after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (echo_b0) b[0] = ~b_oe[0];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 2'b11;
    a   = 2'b11;
    b   = 2'b11;
    step(2);
    chk("rst_a_oe", a_oe, 0);
    chk("rst_b_oe", b_oe, 0);
    chk("rst_stuck", stuck, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step(1);

    // Basic relay A->B with B echo
    echo_b0 = 1'b1;
    a[0] = 1'b0;
    step(7);
    chk("assert_lat_pre", b_oe[0], 0);
    step(1);
    chk("assert_lat", b_oe[0], 1);
    step(12);
    chk("echo_ignored", a_oe[0], 0);
    chk("drive_held", b_oe[0], 1);
    a[0] = 1'b1;
    step(7);
    chk("release_lat_pre", b_oe[0], 1);
    step(1);
    chk("release_lat", b_oe[0], 0);
    chk("release_busy", busy[0], 1);
    chk("release_no_a_oe", a_oe[0], 0);
    step(7);
    chk("holdoff_busy", busy[0], 1);
    step(1);
    chk("holdoff_done", busy[0], 0);
    step(1);
    chk("echo_no_redrive_a", a_oe[0], 0);
    chk("echo_no_redrive_busy", busy[0], 0);
    echo_b0 = 1'b0;
    b[0] = 1'b1;

    // Glitch: 3-cycle pulse rejected
    a[0] = 1'b0;
    step(3);
    a[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("glitch3_b_oe", b_oe[0], 0);
    end
    // 4-cycle pulse accepted once
    a[0] = 1'b0;
    step(4);
    a[0] = 1'b1;
    step(3);
    chk("glitch4_pre", b_oe[0], 0);
    step(1);
    chk("glitch4_assert", b_oe[0], 1);
    step(3);
    chk("glitch4_hold", b_oe[0], 1);
    step(1);
    chk("glitch4_release", b_oe[0], 0);
    step(8);
    chk("glitch4_idle", busy[0], 0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("glitch4_once", b_oe[0], 0);
    end

    // Simultaneous fall on channel 1: A wins, B re-arbitrated after hold-off
    a[1] = 1'b0;
    b[1] = 1'b0;
    step(8);
    chk("sim_b_oe", b_oe[1], 1);
    chk("sim_a_oe", a_oe[1], 0);
    a[1] = 1'b1;
    step(7);
    chk("sim_hold", b_oe[1], 1);
    step(1);
    chk("sim_release", b_oe[1], 0);
    chk("sim_release_busy", busy[1], 1);
    step(8);
    chk("sim_idle_a_oe", a_oe[1], 0);
    chk("sim_idle_busy", busy[1], 0);
    step(1);
    chk("sim_b_drives", a_oe[1], 1);

    // Stuck on channel 0 via B held low
    b[0] = 1'b0;
    step(8);
    chk("stuck_entry_a_oe", a_oe[0], 1);
    step(99);
    chk("stuck_pre_a_oe", a_oe[0], 1);
    chk("stuck_pre_flag", stuck[0], 0);
    step(1);
    chk("stuck_flag", stuck[0], 1);
    chk("stuck_a_oe", a_oe[0], 0);
    chk("stuck_ch1", stuck[1], 1);
    chk("stuck_ch1_a_oe", a_oe[1], 0);
    b[0] = 1'b1;
    step(7);
    chk("stuck_exit_pre", stuck[0], 1);
    step(1);
    chk("stuck_exit", stuck[0], 0);
    chk("stuck_exit_busy", busy[0], 0);

    // Disable mid-drive
    a[0] = 1'b0;
    step(8);
    chk("dis_drive", b_oe[0], 1);
    en[0] = 1'b0;
    step(1);
    chk("dis_b_oe", b_oe[0], 0);
    chk("dis_busy", busy[0], 0);
    chk("dis_ch1", stuck[1], 1);
    step(2);
    chk("dis_held", b_oe[0], 0);
    en[0] = 1'b1;
    step(1);
    chk("reen_drive", b_oe[0], 1);

    // Move channel 0 into B_DRIVES, channel 1 remains STUCK
    a[0] = 1'b1;
    b[0] = 1'b0;
    step(8);
    chk("pre_rst_release", b_oe[0], 0);
    step(8);
    chk("pre_rst_idle", a_oe[0], 0);
    step(1);
    chk("pre_rst_b_drives", a_oe[0], 1);
    chk("pre_rst_ch1_stuck", stuck[1], 1);

    // Synchronous reset mid-operation
    rst = 1'b1;
    step(1);
    chk("mid_rst_a_oe", a_oe, 0);
    chk("mid_rst_b_oe", b_oe, 0);
    chk("mid_rst_stuck", stuck, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    a   = 2'b11;
    b   = 2'b11;
    step(10);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_a_oe", a_oe, 0);
    chk("post_rst_b_oe", b_oe, 0);
    chk("post_rst_stuck", stuck, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/smbus_bidir_relay.md
# smbus_bidir_relay

Parametrised N-channel open-drain relay for SMBus/I2C SCL and SDA lines that passes each line between a host-side segment (A) and a device-side segment (B) while the PFR core is bypassed. It replaces a per-line buffer with a clocked direction-arbitration FSM per channel that adds:
- input synchronisation and glitch filtering,
- echo suppression,
- a programmable release hold-off,
- a stuck-low timeout with status reporting.

Tri-state pads sit in the top level. This block only sees pad inputs and produces active-high pull-low enables.

## Interface
Parameters:
- NUM_CH, 6: number of independent relayed lines (each SCL or SDA is one channel).
- FILTER_LEN, 4: consecutive equal synchronised samples required to accept a level change (≥1).
- HOLDOFF_CYC, 8: cycles both inputs are ignored after a release (≥1).
- TIMEOUT_CYC, 65535: maximum cycles one side may hold a line low before the channel is declared stuck.

Ports:
- iClk, input, 1: sole clock.
- iRst, input, 1: synchronous, active-high reset.
- iEnable, input, NUM_CH: per-channel relay enable.
- iA, input, NUM_CH: A-side pad levels (asynchronous).
- iB, input, NUM_CH: B-side pad levels (asynchronous).
- oA_oe, output, NUM_CH: 1 = pull A-side pad low.
- oB_oe, output, NUM_CH: 1 = pull B-side pad low.
- oStuck, output, NUM_CH: 1 = channel in STUCK state.
- oBusy, output, NUM_CH: 1 = channel not IDLE.

## Operation
- **Input conditioning (per side, per channel):**
  - 2-flop synchroniser.
  - FILTER_LEN-deep history of the synchronised value.
  - Filtered flop (reset 1) takes the new level only when all history entries equal it.
- **FSM per channel:** states IDLE, A_DRIVES, B_DRIVES, RELEASE, STUCK. Outputs are decoded combinationally from the state register:
  - oB_oe = A_DRIVES.
  - oA_oe = B_DRIVES.
  - oStuck = STUCK.
  - oBusy = not IDLE.
- **IDLE:**
  - filtA=0 → A_DRIVES.
  - Else filtB=0 → B_DRIVES.
  - If both are low in the same cycle, A wins.
- **A_DRIVES:**
  - Only filtA is watched; the echo on B is ignored.
  - filtA=1 → RELEASE.
  - Timer reaches TIMEOUT_CYC → STUCK.
- **B_DRIVES:** symmetric to A_DRIVES, watching filtB.
- **RELEASE:**
  - Both oe are 0 and both inputs are ignored for HOLDOFF_CYC cycles, then → IDLE.
  - If a side is still low at that point, IDLE re-arbitrates it as a new drive.
- **STUCK:**
  - Both oe are 0.
  - Exit → IDLE when filtA=1 and filtB=1 in the same cycle.
- **Timer:** one per channel, width $clog2(TIMEOUT_CYC+1). Cleared on every state entry; increments in A_DRIVES/B_DRIVES/RELEASE; saturates.
- **iEnable[i]=0:**
  - State is forced to IDLE on the next edge, from any state, so a drive is released mid-operation.
  - Synchronisers and filters keep running.
- **Channel independence:** no shared state beyond clock and reset.

## Timing
- **Reset (iRst=1 at an edge):** all states IDLE, timers 0, synchronisers/history/filtered flops = 1.
  - Outputs while in reset and after: oA_oe=0, oB_oe=0, oStuck=0, oBusy=0.
- **Assert latency:** a level held on iA from before edge k appears as oB_oe=1 after edge k+FILTER_LEN+3, i.e. FILTER_LEN+4 edges counting edge k. With FILTER_LEN=4 that is 8 edges. The same figure applies to B→A.
- **Release latency:** identical, FILTER_LEN+4 edges from iA rising to oB_oe falling.
- **Glitch rejection:** any pulse shorter than FILTER_LEN cycles after synchronisation never changes oe.
- **Timeout:** STUCK is entered on the edge where the timer equals TIMEOUT_CYC. The oe falls in the same cycle as oStuck rises.
- **Hold-off:** RELEASE lasts exactly HOLDOFF_CYC cycles. A new drive in IDLE becomes visible no earlier than one edge after RELEASE exits.
- **Disable/reset mid-drive:** oe deasserts one edge after the iEnable fall or the iRst assertion.

## Test plan
- **Basic relay (NUM_CH=2, FILTER_LEN=4):** iA[0]=0 for 20 cycles → oB_oe[0]=1 on edge 8, falls 8 edges after iA[0] rises, oBusy[0] covers RELEASE, oA_oe[0] stays 0 throughout despite the B echo (drive iB[0]=~oB_oe[0]).
- **Glitch:** iA[0] low for 3 cycles → oB_oe[0] never asserts; then 4 cycles → asserts once.
- **Simultaneous:** iA[1] and iB[1] fall on the same edge → A_DRIVES: oB_oe[1]=1, oA_oe[1]=0; after iA[1] rises and HOLDOFF_CYC=8 elapse with iB[1] still low → B_DRIVES with oA_oe[1]=1.
- **Stuck (TIMEOUT_CYC=100):** hold iB[0]=0 → oStuck[0]=1 and oA_oe[0]=0 exactly 100 cycles after B_DRIVES entry; release both lines → oStuck[0] clears after filter latency.
- **Disable mid-drive:** in A_DRIVES, drop iEnable[0] → oB_oe[0]=0 next edge, channel 1 unaffected; re-enable with iA[0] still low → re-drives on the next edge.
- **Sync reset mid-operation:** assert iRst during B_DRIVES on channel 0 and STUCK on channel 1 → all outputs 0 at that edge; after deassert with pads high → all channels IDLE.
